reg_bus_initiator: RTL and testbench

- Initiator side of the 4-register byte bus (enable/addr/write/read/wdata/rdata/resp) that fronts the FIFO master block.
- Converts single-beat requests (PUSH, POP, STAT, CLR) from a local client into correctly sequenced bus cycles.
- Optionally pre-checks FIFO full/empty in the status register, so the target FIFO never sees an overflow or underflow from this initiator.
- Returns read data and error status through a valid/ready response channel.

---
 rtl/reg_bus_pkg.sv | 56 +++++
 rtl/reg_bus_initiator.sv | 129 ++++++++++++
 tb/tb_reg_bus_initiator.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the 4-register byte bus initiator.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_STAT = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_XFER,
    S_CAPT,
    S_RSP
  } state_e;

  localparam logic [1:0] ADDR_FIFO = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_MEM  = 2'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UNF   = 3;
  localparam int ST_CLR   = 4;

  localparam logic [7:0] CLR_WDATA = 8'h10;

  typedef struct packed {
    logic       en;
    logic [1:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
  } bus_t;

  // Data-cycle bus image for an op; wdata is kept from cur for reads.
  function automatic bus_t xfer_bus(input op_e op, input logic [7:0] data, input bus_t cur);
    bus_t b;
    b    = cur;
    b.en = 1'b1;
    b.rd = 1'b0;
    b.wr = 1'b0;
    unique case (op)
      OP_PUSH: begin b.addr = ADDR_FIFO; b.wr = 1'b1; b.wdata = data; end
      OP_POP:  begin b.addr = ADDR_FIFO; b.rd = 1'b1; end
      OP_STAT: begin b.addr = ADDR_STAT; b.rd = 1'b1; end
      OP_CLR:  begin b.addr = ADDR_STAT; b.wr = 1'b1; b.wdata = CLR_WDATA; end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_bus_initiator.sv
// Single-beat client requests to sequenced register-bus cycles, with optional
// full/empty pre-check so the target FIFO never overflows or underflows.
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter bit CHECK_FLAGS = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [7:0]       req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic             enable,
  output logic [1:0]       addr,
  output logic             write,
  output logic             read,
  output logic [7:0]       wdata,
  input  logic [7:0]       rdata,
  input  logic             resp,
  output logic             proto_err,
  output logic [CNT_W-1:0] ops_done,
  output logic [CNT_W-1:0] ops_refused
);

  state_e     state, state_n;
  op_e        op_q, op_n, req_op_e;
  logic [7:0] byte_q, byte_n;
  bus_t       bus_q, bus_n;
  logic [7:0] data_n;
  logic       err_n;
  logic       refuse;

  assign req_op_e  = op_e'(req_op);
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RSP);
  assign enable    = bus_q.en;
  assign addr      = bus_q.addr;
  assign read      = bus_q.rd;
  assign write     = bus_q.wr;
  assign wdata     = bus_q.wdata;

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    byte_n   = byte_q;
    bus_n    = bus_q;
    bus_n.en = 1'b0;
    bus_n.rd = 1'b0;
    bus_n.wr = 1'b0;
    data_n   = rsp_data;
    err_n    = rsp_err;
    refuse   = (op_q == OP_PUSH && rdata[ST_FULL]) || (op_q == OP_POP && rdata[ST_EMPTY]);
    unique case (state)
      S_IDLE: if (req_valid) begin
        op_n   = req_op_e;
        byte_n = req_wdata;
        data_n = '0;
        err_n  = 1'b0;
        if (CHECK_FLAGS && (req_op_e == OP_PUSH || req_op_e == OP_POP)) begin
          state_n    = S_CHK;
          bus_n.en   = 1'b1;
          bus_n.addr = ADDR_STAT;
          bus_n.rd   = 1'b1;
        end else begin
          state_n = S_XFER;
          bus_n   = xfer_bus(req_op_e, req_wdata, bus_q);
        end
      end
      S_CHK: if (refuse) begin
        err_n   = 1'b1;
        data_n  = '0;
        state_n = S_RSP;
      end else begin
        state_n = S_XFER;
        bus_n   = xfer_bus(op_q, byte_q, bus_q);
      end
      S_XFER: begin
        unique case (op_q)
          OP_POP:  state_n = S_CAPT;
          OP_STAT: begin data_n = rdata; state_n = S_RSP; end
          default: state_n = S_RSP;
        endcase
      end
      // FIFO output register was loaded by the read edge; take it now.
      S_CAPT: begin
        data_n  = rdata;
        state_n = S_RSP;
      end
      S_RSP: if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_PUSH;
      byte_q      <= '0;
      bus_q       <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      proto_err   <= 1'b0;
      ops_done    <= '0;
      ops_refused <= '0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      byte_q   <= byte_n;
      bus_q    <= bus_n;
      rsp_data <= data_n;
      rsp_err  <= err_n;
      if (resp) proto_err <= 1'b1;
      if (state == S_RSP && rsp_ready) begin
        if (rsp_err) begin
          if (ops_refused != '1) ops_refused <= ops_refused + CNT_W'(1);
        end else begin
          if (ops_done != '1) ops_done <= ops_done + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
module tb_reg_bus_initiator;
  import reg_bus_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [7:0]       req_wdata = 8'h00;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             enable;
  logic [1:0]       addr;
  logic             write;
  logic             read;
  logic [7:0]       wdata;
  logic [7:0]       rdata;
  logic             resp;
  logic             resp_drv = 1'b0;
  logic             proto_err;
  logic [CNT_W-1:0] ops_done;
  logic [CNT_W-1:0] ops_refused;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_bus_initiator #(.CHECK_FLAGS(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .enable(enable), .addr(addr), .write(write), .read(read), .wdata(wdata),
    .rdata(rdata), .resp(resp), .proto_err(proto_err),
    .ops_done(ops_done), .ops_refused(ops_refused)
  );

  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic       ovf_q, unf_q;
  logic [7:0] dout;
  logic [7:0] status;
  int         wr0_cnt = 0;
  int         rd0_cnt = 0;

  always_comb begin
    status           = 8'h00;
    status[ST_EMPTY] = (cnt == 3'd0);
    status[ST_FULL]  = (cnt == 3'd4);
    status[ST_OVF]   = ovf_q;
    status[ST_UNF]   = unf_q;
  end
  assign rdata = (addr == ADDR_STAT) ? status : dout;
  assign resp  = resp_drv | (enable && write && addr == ADDR_MEM);

  always @(posedge clk) begin
    if (rst) begin
      wp <= 2'd0; rp <= 2'd0; cnt <= 3'd0; ovf_q <= 1'b0; unf_q <= 1'b0; dout <= 8'h00;
    end else if (enable) begin
      if (addr == ADDR_FIFO && write) begin
        wr0_cnt <= wr0_cnt + 1;
        if (cnt == 3'd4) ovf_q <= 1'b1;
        else begin mem[wp] <= wdata; wp <= wp + 2'd1; cnt <= cnt + 3'd1; end
      end else if (addr == ADDR_FIFO && read) begin
        rd0_cnt <= rd0_cnt + 1;
        if (cnt == 3'd0) unf_q <= 1'b1;
        else begin dout <= mem[rp]; rp <= rp + 2'd1; cnt <= cnt - 3'd1; end
      end else if (addr == ADDR_STAT && write && wdata[ST_CLR]) begin
        wp <= 2'd0; rp <= 2'd0; cnt <= 3'd0; ovf_q <= 1'b0; unf_q <= 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    req_valid = 1'b1; req_op = op; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    rsp_ready = 1'b1;
    issue(op, d);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({enable, addr, read, write, wdata} !== 13'h0) begin
      fails++;
      $display("FAIL reset_bus: got %b required 0", {enable, addr, read, write, wdata});
    end
    tests++;
    if ({rsp_valid, rsp_err, rsp_data, proto_err} !== 11'h0) begin
      fails++;
      $display("FAIL reset_rsp: got %b required 0", {rsp_valid, rsp_err, rsp_data, proto_err});
    end
    tests++;
    if (ops_done !== 16'd0 || ops_refused !== 16'd0) begin
      fails++;
      $display("FAIL reset_cnt: got done=%0d refused=%0d required 0/0", ops_done, ops_refused);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_push();
    issue(OP_PUSH, 8'hA5);
    @(negedge clk); tests++;
    if ({enable, addr, read, write} !== 5'b1_01_1_0) begin
      fails++;
      $display("FAIL push_chk: got %b required 10110", {enable, addr, read, write});
    end
    @(negedge clk); tests++;
    if ({enable, addr, read, write, wdata} !== {5'b1_00_0_1, 8'hA5}) begin
      fails++;
      $display("FAIL push_write: got %h required %h", {enable, addr, read, write, wdata}, {5'b1_00_0_1, 8'hA5});
    end
    @(negedge clk); tests++;
    if ({rsp_valid, rsp_err, rsp_data, req_ready} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL push_rsp: got v=%b e=%b d=%h rdy=%b required 1 0 00 0", rsp_valid, rsp_err, rsp_data, req_ready);
    end
    tests++;
    if ({enable, addr, read, write, wdata} !== {5'b0_00_0_0, 8'hA5}) begin
      fails++;
      $display("FAIL push_hold: got %h required %h", {enable, addr, read, write, wdata}, {5'b0_00_0_0, 8'hA5});
    end
    @(negedge clk); tests++;
    if (ops_done !== 16'd1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL push_done: got done=%0d v=%b rdy=%b required 1 0 1", ops_done, rsp_valid, req_ready);
    end
  endtask

  task automatic test_pop();
    issue(OP_POP, 8'h00);
    @(negedge clk); tests++;
    if ({enable, addr, read, write} !== 5'b1_01_1_0) begin
      fails++;
      $display("FAIL pop_chk: got %b required 10110", {enable, addr, read, write});
    end
    @(negedge clk); tests++;
    if ({enable, addr, read, write} !== 5'b1_00_1_0) begin
      fails++;
      $display("FAIL pop_read: got %b required 10010", {enable, addr, read, write});
    end
    @(negedge clk); tests++;
    if ({enable, addr, rsp_valid} !== 4'b0_00_0) begin
      fails++;
      $display("FAIL pop_capt: got %b required 0000", {enable, addr, rsp_valid});
    end
    @(negedge clk); tests++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'hA5}) begin
      fails++;
      $display("FAIL pop_rsp: got v=%b e=%b d=%h required 1 0 a5", rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk); tests++;
    if (ops_done !== 16'd2) begin
      fails++;
      $display("FAIL pop_done: got %0d required 2", ops_done);
    end
  endtask

  task automatic test_pop_empty();
    int r0;
    r0 = rd0_cnt;
    issue(OP_POP, 8'h00);
    @(negedge clk);
    @(negedge clk); tests++;
    if ({rsp_valid, rsp_err, rsp_data, enable} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL pop_empty_rsp: got v=%b e=%b d=%h en=%b required 1 1 00 0", rsp_valid, rsp_err, rsp_data, enable);
    end
    @(negedge clk); tests++;
    if (ops_refused !== 16'd1 || ops_done !== 16'd2) begin
      fails++;
      $display("FAIL pop_empty_cnt: got refused=%0d done=%0d required 1 2", ops_refused, ops_done);
    end
    tests++;
    if (rd0_cnt != r0 || unf_q !== 1'b0) begin
      fails++;
      $display("FAIL pop_empty_bus: got fifo reads=%0d unf=%b required %0d 0", rd0_cnt, unf_q, r0);
    end
  endtask

  task automatic test_full();
    bit ok, all_ok;
    int w0;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(OP_PUSH, 8'(i + 1), ok);
      all_ok &= ok;
    end
    tests++;
    if (!all_ok || cnt !== 3'd4) begin
      fails++;
      $display("FAIL fill: got ok=%b depth=%0d required 1 4", all_ok, cnt);
    end
    w0 = wr0_cnt;
    issue(OP_PUSH, 8'h3C);
    @(negedge clk);
    @(negedge clk); tests++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL push_full_rsp: got v=%b e=%b d=%h required 1 1 00", rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk); tests++;
    if (ops_refused !== 16'd2 || wr0_cnt != w0 || ovf_q !== 1'b0) begin
      fails++;
      $display("FAIL push_full_cnt: got refused=%0d writes=%0d ovf=%b required 2 %0d 0", ops_refused, wr0_cnt, ovf_q, w0);
    end
    issue(OP_STAT, 8'h00);
    @(negedge clk); tests++;
    if ({enable, addr, read, write} !== 5'b1_01_1_0) begin
      fails++;
      $display("FAIL stat_read: got %b required 10110", {enable, addr, read, write});
    end
    @(negedge clk); tests++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h02}) begin
      fails++;
      $display("FAIL stat_rsp: got v=%b e=%b d=%h required 1 0 02", rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk); tests++;
    if (ops_done !== 16'd7) begin
      fails++;
      $display("FAIL stat_done: got %0d required 7", ops_done);
    end
  endtask

  task automatic test_clr_hold();
    rsp_ready = 1'b0;
    issue(OP_CLR, 8'hFF);
    @(negedge clk); tests++;
    if ({enable, addr, read, write, wdata} !== {5'b1_01_0_1, 8'h10}) begin
      fails++;
      $display("FAIL clr_write: got %h required %h", {enable, addr, read, write, wdata}, {5'b1_01_0_1, 8'h10});
    end
    @(negedge clk); tests++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL clr_rsp: got v=%b e=%b d=%h required 1 0 00", rsp_valid, rsp_err, rsp_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL clr_hold%0d: got v=%b rdy=%b required 1 0", k, rsp_valid, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk); tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || ops_done !== 16'd8 || cnt !== 3'd0) begin
      fails++;
      $display("FAIL clr_release: got v=%b rdy=%b done=%0d depth=%0d required 0 1 8 0", rsp_valid, req_ready, ops_done, cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    run_op(OP_PUSH, 8'h77, ok);
    tests++;
    if (!ok || ops_done !== 16'd9) begin
      fails++;
      $display("FAIL mid_setup: got ok=%b done=%0d required 1 9", ok, ops_done);
    end
    issue(OP_POP, 8'h00);
    @(negedge clk);
    @(negedge clk); tests++;
    if ({enable, addr, read, write} !== 5'b1_00_1_0) begin
      fails++;
      $display("FAIL mid_xfer: got %b required 10010", {enable, addr, read, write});
    end
    rst = 1'b1;
    @(negedge clk); tests++;
    if ({enable, read, write, rsp_valid} !== 4'b0 || ops_done !== 16'd0 || ops_refused !== 16'd0) begin
      fails++;
      $display("FAIL mid_reset: got strobes=%b done=%0d refused=%0d required 0000 0 0", {enable, read, write, rsp_valid}, ops_done, ops_refused);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || enable) seen = 1'b1;
    end
    tests++;
    if (seen || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_abandon: got activity=%b rdy=%b required 0 1", seen, req_ready);
    end
  endtask

  task automatic test_proto();
    resp_drv = 1'b1;
    @(negedge clk);
    resp_drv = 1'b0;
    tests++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("FAIL proto_set: got %b required 1", proto_err);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("FAIL proto_sticky: got %b required 1", proto_err);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (proto_err !== 1'b0) begin
      fails++;
      $display("FAIL proto_clear: got %b required 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_pop_empty();
    test_full();
    test_clr_hold();
    test_reset_mid();
    test_proto();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
